// File: rtl/inst_encoder.sv
// RISC-V instruction word encoder feeding a 2-entry output FIFO with a handshake counter.
// Optional immediate range checking is enabled by defining INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [31:0]        imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_err,
    output logic [COUNT_W-1:0] inst_count
);

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_RSVD  = 3'd7;

    logic [31:0]        enc_inst;
    logic               enc_err;
    logic [32:0]        mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;
    logic [COUNT_W-1:0] count_q;
    logic               push;
    logic               pop;
    logic [32:0]        head;

    always_comb begin
        enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt)
            FMT_I:     enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:     enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:     enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:     enc_inst = {imm[31:12], rd, opcode};
            FMT_J:     enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_SHAMT: enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            default:   enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

    // A signed immediate fits its field when every bit above the field's sign bit matches it.
    always_comb begin
        enc_err = 1'b0;
`ifdef INST_ENCODER_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: enc_err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        enc_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            FMT_J:        enc_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            FMT_U:        enc_err = |imm[11:0];
            FMT_SHAMT:    enc_err = |imm[31:5];
            FMT_RSVD:     enc_err = 1'b1;
            default:      enc_err = 1'b0;
        endcase
`endif
    end

    // in_ready depends only on registered occupancy and rst, never on out_ready.
    assign in_ready   = (occ_q != 2'd2) && !rst;
    assign out_valid  = (occ_q != 2'd0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign head       = mem_q[rd_ptr_q];
    assign out_inst   = out_valid ? head[31:0] : 32'd0;
    assign out_err    = out_valid ? head[32] : 1'b0;
    assign inst_count = count_q;
    assign occ_d      = occ_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {enc_err, enc_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                count_q  <= count_q + COUNT_W'(1);
            end
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomised and directed bench for inst_encoder against a field-arithmetic reference model.
module tb_inst_encoder;

    localparam int CW = 16;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic          out_err;
    logic [CW-1:0] inst_count;

    int checks = 0;
    int passed = 0;
    bit verbose = 1'b1;

    logic [32:0]   exp_q [$];
    logic [CW-1:0] exp_count;

    // Per-cycle snapshot: DUT outputs and model state as they stood during the handshake cycle.
    logic          s_valid, s_err, s_ready;
    logic [31:0]   s_inst;
    logic [CW-1:0] s_count, m_count;
    int            m_size;
    logic [32:0]   m_head;
    bit            m_push, m_pop;

    inst_encoder #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input req_t r);
        logic [31:0] u, w, base;
        longint      s;
        logic        e;
        u    = r.imm;
        s    = longint'($signed(r.imm));
        e    = 1'b0;
        base = (32'(r.f3) << 12) | (32'(r.rd) << 7) | 32'(r.op);
        case (r.fmt)
            3'd1: w = ((u % 4096) << 20) | (32'(r.rs1) << 15) | base;
            3'd2: w = (((u / 32) % 128) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
                      | (32'(r.f3) << 12) | ((u % 32) << 7) | 32'(r.op);
            3'd3: w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (32'(r.rs2) << 20)
                      | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (((u / 2) % 16) << 8)
                      | (((u / 2048) % 2) << 7) | 32'(r.op);
            3'd4: w = (u / 4096) * 4096 + (32'(r.rd) << 7) + 32'(r.op);
            3'd5: w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21)
                      | (((u / 2048) % 2) << 20) | (((u / 4096) % 256) << 12)
                      | (32'(r.rd) << 7) | 32'(r.op);
            3'd6: w = (32'(r.f7) << 25) | ((u % 32) << 20) | (32'(r.rs1) << 15) | base;
            default: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | base;
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        case (r.fmt)
            3'd1, 3'd2: e = (s < -2048) || (s > 2047);
            3'd3:       e = ((u % 2) != 0) || (s < -4096) || (s > 4095);
            3'd5:       e = ((u % 2) != 0) || (s < -1048576) || (s > 1048575);
            3'd4:       e = (u % 4096) != 0;
            3'd6:       e = u > 31;
            3'd7:       e = 1'b1;
            default:    e = 1'b0;
        endcase
`else
        if (s == 0) e = 1'b0;
`endif
        return {e, w};
    endfunction

    function automatic logic [31:0] rnd_imm();
        int k;
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 63)) - 32'd32;
            1: return $urandom;
            2: return $urandom & 32'hFFFFF000;
            3: begin
                k = $urandom_range(0, 11);
                case (k)
                    0: return 32'd2047;      1: return -32'sd2048;
                    2: return 32'd2048;      3: return -32'sd2049;
                    4: return 32'd4094;      5: return -32'sd4096;
                    6: return 32'd4096;      7: return 32'd31;
                    8: return 32'd32;        9: return 32'd1048574;
                    10: return -32'sd1048576;
                    default: return 32'd1048576;
                endcase
            end
            default: return 32'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.fmt = 3'($urandom_range(0, 7));
        r.op  = 7'($urandom);
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.f3  = 3'($urandom);
        r.f7  = 7'($urandom);
        r.imm = rnd_imm();
        return r;
    endfunction

    task automatic step(input bit v, input req_t r, input bit ordy);
        @(negedge clk);
        s_valid = out_valid; s_inst = out_inst; s_err = out_err;
        s_ready = in_ready;  s_count = inst_count;
        m_size  = exp_q.size();
        m_head  = (m_size > 0) ? exp_q[0] : 33'd0;
        m_count = exp_count;
        in_valid = v; fmt = r.fmt; opcode = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
        funct3 = r.f3; funct7 = r.f7; imm = r.imm; out_ready = ordy;
        m_push = v && (m_size < 2);
        m_pop  = ordy && (m_size > 0);
        @(posedge clk);
        if (m_pop) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 1'b1;
            if (verbose) $display("pop  inst=%08h err=%0b count=%0d", s_inst, s_err, exp_count);
        end
        if (m_push) begin
            exp_q.push_back(model(r));
            if (verbose) $display("push fmt=%0d imm=%08h", r.fmt, r.imm);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_count = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got=%0b want=0", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        exp_count = '0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid); else passed++;
        checks++; if (out_inst !== 32'd0) $display("FAIL reset_out_inst got=%08h want=0", out_inst); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%0b want=0", out_err); else passed++;
        checks++; if (inst_count !== 16'd0) $display("FAIL reset_count got=%0d want=0", inst_count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_high got=%0b want=1", in_ready); else passed++;
    endtask

    task automatic test_directed();
        req_t        tbl [5];
        logic [31:0] want [5];
        logic        werr [5];
        tbl[0] = '{fmt: 3'd1, op: 7'h13, rd: 5'd1, rs1: 5'd0, rs2: 5'h1F, f3: 3'd0, f7: 7'h7F, imm: 32'd5};
        tbl[1] = '{fmt: 3'd3, op: 7'h63, rd: 5'h1F, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'h55, imm: -32'sd4};
        tbl[2] = '{fmt: 3'd5, op: 7'h6F, rd: 5'd1, rs1: 5'h1F, rs2: 5'h1F, f3: 3'd0, f7: 7'h7F, imm: 32'd8};
        tbl[3] = '{fmt: 3'd4, op: 7'h37, rd: 5'd2, rs1: 5'h0A, rs2: 5'h15, f3: 3'd0, f7: 7'h2A, imm: 32'h12345000};
        tbl[4] = '{fmt: 3'd1, op: 7'h13, rd: 5'd0, rs1: 5'd0, rs2: 5'h1F, f3: 3'd0, f7: 7'h7F, imm: 32'd2048};
        want[0] = 32'h00500093; want[1] = 32'hFE000EE3; want[2] = 32'h008000EF;
        want[3] = 32'h12345137; want[4] = 32'h80000013;
        werr[0] = 1'b0; werr[1] = 1'b0; werr[2] = 1'b0; werr[3] = 1'b0;
`ifdef INST_ENCODER_RANGE_CHECK_EN
        werr[4] = 1'b1;
`else
        werr[4] = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tbl[i], 1'b0);
            checks++; if (out_valid !== 1'b1) $display("FAIL dir%0d_latency out_valid=%0b want=1", i, out_valid); else passed++;
            checks++; if (out_inst !== want[i]) $display("FAIL dir%0d_inst got=%08h want=%08h", i, out_inst, want[i]); else passed++;
            checks++; if (out_err !== werr[i]) $display("FAIL dir%0d_err got=%0b want=%0b", i, out_err, werr[i]); else passed++;
            step(1'b0, tbl[i], 1'b1);
            checks++; if (out_valid !== 1'b0) $display("FAIL dir%0d_drain out_valid=%0b want=0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        req_t        r [3];
        logic [32:0] order [3];
        int          n_pop;
        bit          third_in;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            r[i] = rnd_req();
            r[i].fmt = 3'd1;
            order[i] = model(r[i]);
        end
        step(1'b1, r[0], 1'b0);
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after1 got=%0b want=1", in_ready); else passed++;
        step(1'b1, r[1], 1'b0);
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_after2 got=%0b want=0", in_ready); else passed++;
        step(1'b1, r[2], 1'b0);
        checks++; if (s_ready !== 1'b0) $display("FAIL b2b_third_refused in_ready=%0b want=0", s_ready); else passed++;
        checks++; if (out_inst !== order[0][31:0]) $display("FAIL b2b_hold got=%08h want=%08h", out_inst, order[0][31:0]); else passed++;
        n_pop = 0;
        third_in = m_push;
        for (int k = 0; k < 8 && n_pop < 3; k++) begin
            step(!third_in, r[2], 1'b1);
            if (m_push) third_in = 1'b1;
            if (m_pop) begin
                checks++;
                if (s_inst !== order[n_pop][31:0])
                    $display("FAIL b2b_order%0d got=%08h want=%08h", n_pop, s_inst, order[n_pop][31:0]);
                else passed++;
                n_pop++;
            end
        end
        checks++; if (n_pop != 3) $display("FAIL b2b_drain_timeout popped=%0d want=3", n_pop); else passed++;
        checks++; if (inst_count !== 16'd3) $display("FAIL b2b_count got=%0d want=3", inst_count); else passed++;
    endtask

    task automatic test_mid_reset();
        req_t r;
        do_reset();
        r = rnd_req();
        step(1'b1, r, 1'b0);
        step(1'b0, r, 1'b1);
        step(1'b1, rnd_req(), 1'b0);
        step(1'b1, rnd_req(), 1'b0);
        checks++; if (out_valid !== 1'b1) $display("FAIL mrst_pre_valid got=%0b want=1", out_valid); else passed++;
        checks++; if (inst_count !== 16'd1) $display("FAIL mrst_pre_count got=%0d want=1", inst_count); else passed++;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready_during got=%0b want=0", in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid got=%0b want=0", out_valid); else passed++;
        checks++; if (inst_count !== 16'd0) $display("FAIL mrst_count got=%0d want=0", inst_count); else passed++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        exp_count = '0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready_after got=%0b want=1", in_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, r, 1'b1);
            checks++; if (s_valid !== 1'b0) $display("FAIL mrst_stale%0d out_valid=%0b want=0", i, s_valid); else passed++;
        end
    endtask

    task automatic test_wrap();
        req_t r;
        int   n;
        do_reset();
        r = '{fmt: 3'd1, op: 7'h13, rd: 5'd3, rs1: 5'd4, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'd7};
        verbose = 1'b0;
        n = 0;
        while (exp_count != 16'hFFFF && n < 70000) begin
            step(1'b1, r, 1'b1);
            n++;
        end
        checks++; if (inst_count !== 16'hFFFF) $display("FAIL wrap_preset got=%04h want=ffff", inst_count); else passed++;
        step(1'b0, r, 1'b1);
        verbose = 1'b1;
        checks++; if (inst_count !== 16'h0000) $display("FAIL wrap_zero got=%04h want=0000", inst_count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL wrap_empty out_valid=%0b want=0", out_valid); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_req(), 1'($urandom_range(0, 2) != 0));
            checks++; if (s_valid !== 1'(m_size > 0)) $display("FAIL rnd%0d_valid got=%0b want=%0b", i, s_valid, m_size > 0); else passed++;
            checks++; if (s_ready !== 1'(m_size < 2)) $display("FAIL rnd%0d_ready got=%0b want=%0b", i, s_ready, m_size < 2); else passed++;
            checks++; if (s_count !== m_count) $display("FAIL rnd%0d_count got=%0d want=%0d", i, s_count, m_count); else passed++;
            if (m_size > 0) begin
                checks++; if (s_inst !== m_head[31:0]) $display("FAIL rnd%0d_inst got=%08h want=%08h", i, s_inst, m_head[31:0]); else passed++;
                checks++; if (s_err !== m_head[32]) $display("FAIL rnd%0d_err got=%0b want=%0b", i, s_err, m_head[32]); else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        exp_count = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
